// File: rtl/override_pkg.sv
// Shared types and constants for the override scheduler.
package override_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam int W_DEF     = 8;
    localparam int CNT_W_DEF = 4;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/override_sched_rr_arb2.sv
// Two-way round-robin pick; rr_ptr_i names the requester preferred on a tie.
module rr_arb2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic rr_ptr_i,
    output logic gv_o,
    output logic gidx_o
);

    always_comb begin
        gv_o   = req0_i | req1_i;
        gidx_o = (req0_i & req1_i) ? rr_ptr_i : req1_i;
    end

endmodule

// File: rtl/override_sched.sv
// Output register x follows a, except while one of two requesters holds an
// override granted through a round-robin req/gnt/done handshake.
module override_sched
    import override_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     a,
    input  logic             req0,
    input  logic [W-1:0]     val0,
    input  logic [CNT_W-1:0] len0,
    input  logic             req1,
    input  logic [W-1:0]     val1,
    input  logic [CNT_W-1:0] len1,
    input  logic             abort,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [W-1:0]     x,
    output logic             ovr_active
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rr_ptr_q, rr_ptr_d;
    logic             owner_q, owner_d;
    logic [W-1:0]     x_q, x_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             ovr_q, ovr_d;

    logic gv;
    logic gidx;

    // Length 0 behaves like 1; the counter holds the edges left after the grant.
    function automatic logic [CNT_W-1:0] hold_cnt(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : len - 1'b1;
    endfunction

    rr_arb2 u_arb (
        .req0_i   (req0),
        .req1_i   (req1),
        .rr_ptr_i (rr_ptr_q),
        .gv_o     (gv),
        .gidx_o   (gidx)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        x_d      = x_q;
        ovr_d    = ovr_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        done0_d  = 1'b0;
        done1_d  = 1'b0;

        case (state_q)
            IDLE: begin
                x_d = a;
                if (gv) begin
                    state_d = HOLD;
                    owner_d = gidx;
                    ovr_d   = 1'b1;
                    if (gidx == REQ1) begin
                        x_d    = val1;
                        cnt_d  = hold_cnt(len1);
                        gnt1_d = 1'b1;
                    end else begin
                        x_d    = val0;
                        cnt_d  = hold_cnt(len0);
                        gnt0_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0 || abort) begin
                    state_d  = RELEASE;
                    x_d      = a;
                    ovr_d    = 1'b0;
                    rr_ptr_d = ~owner_q;
                    done0_d  = (owner_q == REQ0);
                    done1_d  = (owner_q == REQ1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RELEASE: begin
                // Guard cycle: no grant can be issued on this edge.
                x_d     = a;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= REQ0;
            owner_q  <= REQ0;
            x_q      <= '0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            x_q      <= x_d;
            gnt0_q   <= gnt0_d;
            gnt1_q   <= gnt1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            ovr_q    <= ovr_d;
        end
    end

    assign x          = x_q;
    assign gnt0       = gnt0_q;
    assign gnt1       = gnt1_q;
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign ovr_active = ovr_q;

endmodule

// File: tb/tb_override_sched.sv
// Bench for override_sched: directed vector table, max-hold sequence, and
// randomized traffic against a cycles-remaining reference model.
module tb_override_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a;
    logic       req0, req1, abort;
    logic [7:0] val0, val1;
    logic [3:0] len0, len1;
    logic       gnt0, gnt1, done0, done1, ovr_active;
    logic [7:0] x;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    override_sched dut (
        .clk        (clk),
        .rst        (rst),
        .a          (a),
        .req0       (req0),
        .val0       (val0),
        .len0       (len0),
        .req1       (req1),
        .val1       (val1),
        .len1       (len1),
        .abort      (abort),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .done0      (done0),
        .done1      (done1),
        .x          (x),
        .ovr_active (ovr_active)
    );

    // flags = {gnt0, gnt1, done0, done1, ovr_active}
    typedef struct {
        logic       rst;
        logic [7:0] a;
        logic       r0;
        logic [7:0] v0;
        logic [3:0] l0;
        logic       r1;
        logic [7:0] v1;
        logic [3:0] l1;
        logic       ab;
        logic [7:0] ex;
        logic [4:0] ef;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic [7:0] av, logic r0, logic [7:0] v0,
                                logic [3:0] l0, logic r1, logic [7:0] v1, logic [3:0] l1,
                                logic ab, logic [7:0] ex, logic [4:0] ef);
        vec_t v;
        v.rst = r; v.a = av; v.r0 = r0; v.v0 = v0; v.l0 = l0;
        v.r1 = r1; v.v1 = v1; v.l1 = l1; v.ab = ab; v.ex = ex; v.ef = ef;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [7:0] ex, logic [4:0] ef);
        logic [4:0] got;
        got = {gnt0, gnt1, done0, done1, ovr_active};
        vectors++;
        if (x !== ex || got !== ef) begin
            miscompares++;
            $display("FAIL %s: got x=%h flags=%b, expected x=%h flags=%b",
                     name, x, got, ex, ef);
        end
    endtask

    // Reference model: tracks how many override cycles are still owed.
    int         m_left;
    bit         m_guard, m_pref, m_owner;
    logic [7:0] m_x;
    logic [4:0] m_f;

    task automatic model_edge();
        bit take0, take1;
        m_f = 5'b0;
        if (rst) begin
            m_x = 8'h00; m_left = 0; m_guard = 0; m_pref = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 || abort) begin
                m_left  = 0;
                m_x     = a;
                m_guard = 1;
                m_pref  = !m_owner;
                m_f     = m_owner ? 5'b00010 : 5'b00100;
            end else begin
                m_f = 5'b00001;
            end
        end else if (m_guard) begin
            m_guard = 0;
            m_x     = a;
        end else begin
            take0 = req0 && (!req1 || !m_pref);
            take1 = req1 && !take0;
            if (take0) begin
                m_owner = 0; m_x = val0; m_left = (len0 == 0) ? 1 : int'(len0);
                m_f = 5'b10001;
            end else if (take1) begin
                m_owner = 1; m_x = val1; m_left = (len1 == 0) ? 1 : int'(len1);
                m_f = 5'b01001;
            end else begin
                m_x = a;
            end
        end
    endtask

    initial begin
        int hold_cycles;
        bit seen_done;

        rst = 1; a = 0; req0 = 0; req1 = 0; val0 = 0; val1 = 0;
        len0 = 0; len1 = 0; abort = 0;

        tbl.push_back(mk(1, 8'h11, 0, 8'h00,  0, 0, 8'h00, 0, 0, 8'h00, 5'b00000));
        tbl.push_back(mk(0, 8'h3C, 0, 8'h00,  0, 0, 8'h00, 0, 0, 8'h3C, 5'b00000));
        tbl.push_back(mk(0, 8'h3D, 0, 8'h00,  0, 0, 8'h00, 0, 0, 8'h3D, 5'b00000));
        tbl.push_back(mk(0, 8'h40, 1, 8'hA5,  3, 0, 8'h00, 0, 0, 8'hA5, 5'b10001));
        tbl.push_back(mk(0, 8'h41, 0, 8'hA5,  3, 0, 8'h00, 0, 0, 8'hA5, 5'b00001));
        tbl.push_back(mk(0, 8'h42, 0, 8'hA5,  3, 0, 8'h00, 0, 0, 8'hA5, 5'b00001));
        tbl.push_back(mk(0, 8'h43, 0, 8'hA5,  3, 0, 8'h00, 0, 0, 8'h43, 5'b00100));
        tbl.push_back(mk(0, 8'h44, 1, 8'hA5,  1, 1, 8'h0F, 0, 0, 8'h44, 5'b00000));
        tbl.push_back(mk(0, 8'h45, 1, 8'hA5,  1, 1, 8'h0F, 0, 0, 8'h0F, 5'b01001));
        tbl.push_back(mk(0, 8'h46, 1, 8'hA5,  1, 1, 8'h0F, 0, 0, 8'h46, 5'b00010));
        tbl.push_back(mk(0, 8'h47, 1, 8'hA5,  1, 1, 8'h0F, 0, 0, 8'h47, 5'b00000));
        tbl.push_back(mk(0, 8'h48, 1, 8'hA5,  1, 1, 8'h0F, 0, 0, 8'hA5, 5'b10001));
        tbl.push_back(mk(0, 8'h49, 1, 8'hA5,  1, 1, 8'h0F, 0, 0, 8'h49, 5'b00100));
        tbl.push_back(mk(0, 8'h4A, 1, 8'hA5,  1, 1, 8'h0F, 0, 0, 8'h4A, 5'b00000));
        tbl.push_back(mk(0, 8'h4B, 1, 8'hA5,  1, 1, 8'h0F, 0, 0, 8'h0F, 5'b01001));
        tbl.push_back(mk(0, 8'h4C, 1, 8'hA5,  1, 1, 8'h0F, 0, 0, 8'h4C, 5'b00010));
        tbl.push_back(mk(0, 8'h4D, 1, 8'h77, 10, 0, 8'h0F, 0, 0, 8'h4D, 5'b00000));
        tbl.push_back(mk(0, 8'h4E, 1, 8'h77, 10, 0, 8'h0F, 0, 0, 8'h77, 5'b10001));
        tbl.push_back(mk(0, 8'h4F, 0, 8'h77, 10, 0, 8'h0F, 0, 0, 8'h77, 5'b00001));
        tbl.push_back(mk(0, 8'h50, 0, 8'h77, 10, 0, 8'h0F, 0, 0, 8'h77, 5'b00001));
        tbl.push_back(mk(0, 8'h51, 0, 8'h77, 10, 0, 8'h0F, 0, 1, 8'h51, 5'b00100));
        tbl.push_back(mk(0, 8'h52, 0, 8'h77, 10, 0, 8'h0F, 0, 1, 8'h52, 5'b00000));
        tbl.push_back(mk(0, 8'h53, 1, 8'h66,  5, 0, 8'h0F, 0, 0, 8'h66, 5'b10001));
        tbl.push_back(mk(0, 8'h54, 0, 8'h66,  5, 0, 8'h0F, 0, 0, 8'h66, 5'b00001));
        tbl.push_back(mk(1, 8'h55, 0, 8'h66,  5, 0, 8'h0F, 0, 0, 8'h00, 5'b00000));
        tbl.push_back(mk(0, 8'h56, 1, 8'hA5,  1, 1, 8'h0F, 0, 0, 8'hA5, 5'b10001));
        tbl.push_back(mk(0, 8'h57, 0, 8'hA5,  1, 0, 8'h0F, 0, 0, 8'h57, 5'b00100));
        tbl.push_back(mk(0, 8'h58, 0, 8'hA5,  1, 0, 8'h0F, 0, 0, 8'h58, 5'b00000));
        tbl.push_back(mk(0, 8'h59, 1, 8'h12,  2, 0, 8'h0F, 0, 1, 8'h12, 5'b10001));
        tbl.push_back(mk(0, 8'h5A, 0, 8'h12,  2, 0, 8'h0F, 0, 0, 8'h12, 5'b00001));
        tbl.push_back(mk(0, 8'h5B, 0, 8'h12,  2, 0, 8'h0F, 0, 0, 8'h5B, 5'b00100));

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].rst; a = tbl[i].a; abort = tbl[i].ab;
            req0 = tbl[i].r0; val0 = tbl[i].v0; len0 = tbl[i].l0;
            req1 = tbl[i].r1; val1 = tbl[i].v1; len1 = tbl[i].l1;
            tick();
            check($sformatf("tbl[%0d]", i), tbl[i].ex, tbl[i].ef);
        end

        // Maximum hold length: 15 override cycles, no counter wrap.
        req0 = 0; req1 = 1; val1 = 8'hC3; len1 = 4'd15; abort = 0; a = 8'h60;
        tick();
        check("maxhold_guard", 8'h60, 5'b00000);
        a = 8'h61;
        tick();
        check("maxhold_grant", 8'hC3, 5'b01001);
        req1 = 0;
        hold_cycles = 1;
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            a = 8'(8'h62 + i);
            tick();
            if (done1) begin
                seen_done = 1;
                check("maxhold_release", a, 5'b00010);
                break;
            end
            if (ovr_active && x == 8'hC3) hold_cycles++;
        end
        vectors++;
        if (!seen_done || hold_cycles != 15) begin
            miscompares++;
            $display("FAIL maxhold_len: got %0d cycles (done seen %0d), expected 15 cycles",
                     hold_cycles, seen_done);
        end

        // Randomized traffic against the reference model.
        rst = 1; req0 = 0; req1 = 0; abort = 0;
        model_edge();
        tick();
        check("rand_reset", m_x, m_f);
        rst = 0;
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 149) == 0);
            a     = 8'($urandom);
            req0  = ($urandom_range(0, 1) == 1);
            req1  = ($urandom_range(0, 1) == 1);
            val0  = 8'($urandom);
            val1  = 8'($urandom);
            len0  = 4'($urandom_range(0, 15));
            len1  = 4'($urandom_range(0, 15));
            abort = ($urandom_range(0, 9) == 0);
            model_edge();
            tick();
            check($sformatf("rand[%0d]", c), m_x, m_f);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/override_sched.md
Name: override_sched

Overview:
- Owns output register `x`. Normally `x` tracks input `a` every `clk` edge.
- Two requesters can each take exclusive control of `x` and force it to a value for a programmed number of cycles.
- Requests are granted through a req/gnt/done handshake, with round-robin arbitration between the two requesters.
- Replaces ad-hoc procedural override of `x` with one sequenced, synthesizable scheduler.

Parameters:
- W, 8, width of `a`, `x` and the override values.
- CNT_W, 4, width of the hold-length fields.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- a  in  W  normal data source for `x`.
- req0  in  1  requester 0 override request; held until `gnt0`.
- val0  in  W  requester 0 override value; sampled at grant.
- len0  in  CNT_W  requester 0 hold length in cycles; sampled at grant; 0 is treated as 1.
- req1, val1, len1  in  1/W/CNT_W  requester 1; same rules as requester 0.
- abort  in  1  ends the current override early.
- gnt0, gnt1  out  1  one-cycle grant pulses.
- done0, done1  out  1  one-cycle completion pulses.
- x  out  W  registered output.
- ovr_active  out  1  high while `x` is overridden.

Behaviour:
- Reset (`rst`=1 at an edge):
  - x=0; gnt0=gnt1=done0=done1=0; ovr_active=0.
  - state=IDLE; rr_ptr=0 (requester 0 preferred); counter=0.
- Reset mid-HOLD aborts silently: no done pulse.
- States: IDLE, HOLD, RELEASE.
- IDLE:
  - Every edge: x<=a.
  - If any req is high at an edge, grant it; if both are high, grant the one selected by rr_ptr.
  - At the granting edge: x<=val_g, gnt_g<=1 for one cycle, ovr_active<=1, counter<=max(len_g,1)-1, state<=HOLD.
- HOLD:
  - x holds the latched value; `a` and the req inputs are ignored.
  - At each edge: if counter==0 or abort=1, go to RELEASE; otherwise decrement counter.
  - Net effect: x shows the override value for exactly max(len,1) cycles, measured from the granting edge.
- HOLD to RELEASE edge:
  - x<=a; done_g<=1; ovr_active<=0.
  - rr_ptr<=other requester. This applies even if the other requester is idle.
- RELEASE (guard cycle):
  - At the next edge: x<=a, done_g<=0, state<=IDLE.
  - No grant is possible at this edge.
  - Earliest next grant is the edge after that.
- Handshake rules:
  - A requester must drop req the cycle after its gnt.
  - A req still high when the scheduler returns to IDLE counts as a new request.
  - A req dropped before its grant is never granted.
  - Requests are not queued; pending reqs simply wait.
- Outputs: gnt and done are registered. gnt0 and gnt1 are never high together; likewise done0 and done1.
- abort: in IDLE or RELEASE it has no effect. abort at the granting edge is ignored because state is not yet HOLD.
- Max hold: len=2^CNT_W-1 (15 at defaults) gives 15 cycles. Counter never wraps.

Decomposition:
- Package `override_pkg`:
  - state enum {IDLE, HOLD, RELEASE}.
  - Defaults for W and CNT_W.
  - Requester index constants REQ0=0, REQ1=1.
- Sub-module `rr_arb2`:
  - Combinational 2-way round-robin pick from req0, req1 and rr_ptr.
  - Outputs grant-valid and grant-index.
  - rr_ptr update stays in the parent.

Test Plan:
- Reset then a=8'h3C, no req → x=8'h3C one edge after a changes; ovr_active=0; no gnt or done.
- req0=1, val0=8'hA5, len0=3, a toggling → gnt0 pulses at grant edge E0; x=8'hA5 from E0 through E3; done0=1 during E3..E4; x follows a from E3.
- req0 and req1 both held high, len=1 each, starting from reset → grant order req0, req1, req0 alternating; each next grant lands 2 edges after the previous release (RELEASE guard).
- len1=0, val1=8'h0F → x=8'h0F for exactly 1 cycle; done1 pulses; requester 1 is then deprioritized.
- req0, len0=10, abort=1 at the 3rd HOLD edge → RELEASE at that edge; done0 pulses; x follows a.
- rst asserted mid-HOLD → next edge: x=0, ovr_active=0, no done; rr_ptr=0.
